pair_sweep_gen: RTL and testbench

//   Synthesizable stimulus sequencer sitting directly upstream of the DUT interface wrapper.

---
 rtl/pair_sweep_gen_if.sv | 38 +++
 rtl/pair_sweep_gen.sv | 161 ++++++++++++++++
 tb/tb_pair_sweep_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pair_sweep_gen_if.sv
// Bus between the pair sweep sequencer and the DUT interface wrapper.
interface pair_sweep_gen_if #(
    parameter int IN_SIZE = 4,
    parameter int CNT_W   = 9
);
    logic               start;
    logic               pause;
    logic [IN_SIZE-1:0] in_o;
    logic               phase;
    logic               trig;
    logic [CNT_W-1:0]   sim_idx;
    logic               busy;
    logic               done;

    // Sequencer side: takes start/pause, drives the stimulus bus and markers.
    modport master (
        input  start,
        input  pause,
        output in_o,
        output phase,
        output trig,
        output sim_idx,
        output busy,
        output done
    );

    // Consumer side: launches/pauses the sweep and observes the stimulus.
    modport slave (
        output start,
        output pause,
        input  in_o,
        input  phase,
        input  trig,
        input  sim_idx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/pair_sweep_gen.sv
// Pair sweep stimulus sequencer: applies every ordered pair (i, j), i-major,
// as value i (phase A) then value j (phase B), each held HOLD cycles, with a
// one-cycle trigger at each A->B transition and a running pair index.
module pair_sweep_gen #(
    parameter int IN_SIZE = 4,
    parameter int SIM     = 16,
    parameter int HOLD    = 1,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    pair_sweep_gen_if.master bus
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD - 1);
    localparam logic [IN_SIZE-1:0] VAL_LAST  = IN_SIZE'(SIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        A_PH,
        B_PH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [IN_SIZE-1:0] i_q, i_d;
    logic [IN_SIZE-1:0] j_q, j_d;
    logic [CNT_W-1:0]   idx_q, idx_d;

    logic [IN_SIZE-1:0] in_q, in_d;
    logic               phase_q, phase_d;
    logic               trig_q, trig_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               hold_end;

    assign hold_end = (hold_q == HOLD_LAST);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            in_q    <= '0;
            phase_q <= 1'b0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            i_q     <= i_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            in_q    <= in_d;
            phase_q <= phase_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state: launch, hold counting, pair stepping; pause freezes A/B.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        i_d     = i_q;
        j_d     = j_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = A_PH;
                    hold_d  = '0;
                    i_d     = '0;
                    j_d     = '0;
                    idx_d   = '0;
                end
            end
            A_PH: begin
                if (!bus.pause) begin
                    if (hold_end) begin
                        state_d = B_PH;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            B_PH: begin
                if (!bus.pause) begin
                    if (hold_end) begin
                        hold_d = '0;
                        if (j_q != VAL_LAST) begin
                            j_d     = j_q + 1'b1;
                            idx_d   = idx_q + 1'b1;
                            state_d = A_PH;
                        end else if (i_q != VAL_LAST) begin
                            j_d     = '0;
                            i_d     = i_q + 1'b1;
                            idx_d   = idx_q + 1'b1;
                            state_d = A_PH;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so every
    // output is registered; trig is only the A->B edge, so a pause cannot stretch it.
    always_comb begin
        in_d    = '0;
        phase_d = 1'b0;
        trig_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            A_PH: begin
                in_d   = i_d;
                busy_d = 1'b1;
            end
            B_PH: begin
                in_d    = j_d;
                phase_d = 1'b1;
                trig_d  = (state_q == A_PH);
                busy_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                in_d = '0;
            end
        endcase
    end

    assign bus.in_o    = in_q;
    assign bus.phase   = phase_q;
    assign bus.trig    = trig_q;
    assign bus.sim_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_pair_sweep_gen.sv
// Testbench for pair_sweep_gen: several configurations checked cycle by cycle
// against a pair-list model of the sweep.
module tb_pair_sweep_gen;

    localparam int ND = 5;
    localparam int SIMS  [ND] = '{2, 2, 1, 16, 3};
    localparam int HOLDS [ND] = '{1, 3, 1, 1, 2};

    logic clk;
    logic [ND-1:0] rst_r;
    logic [ND-1:0] start_r;
    logic [ND-1:0] pause_r;
    // {in_o[3:0], phase, trig, sim_idx[8:0], busy, done}
    logic [ND-1:0][16:0] obs;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : gd
            pair_sweep_gen_if #(.IN_SIZE(4), .CNT_W(9)) bus ();
            pair_sweep_gen #(
                .IN_SIZE(4),
                .SIM(SIMS[g]),
                .HOLD(HOLDS[g]),
                .CNT_W(9)
            ) dut (
                .clk(clk),
                .rst(rst_r[g]),
                .bus(bus)
            );
            assign bus.start = start_r[g];
            assign bus.pause = pause_r[g];
            assign obs[g] = {bus.in_o, bus.phase, bus.trig, bus.sim_idx, bus.busy, bus.done};
        end
    endgenerate

    // Expected outputs at non-paused step t of a sweep (t == 2*hold*sim*sim is DONE).
    function automatic logic [16:0] expv(int sim, int hold, int t, bit paused);
        int p, r, v;
        bit ph, tr;
        if (t == 2 * hold * sim * sim)
            return {4'd0, 1'b0, 1'b0, 9'(sim * sim - 1), 1'b0, 1'b1};
        p  = t / (2 * hold);
        r  = t % (2 * hold);
        ph = (r >= hold);
        v  = ph ? (p % sim) : (p / sim);
        tr = ph && (r == hold) && !paused;
        return {4'(v), ph, tr, 9'(p), 1'b1, 1'b0};
    endfunction

    task automatic chk(input int k, input logic [16:0] exp, input string tag);
        checks++;
        assert (obs[k] === exp)
        else begin
            errors++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs[k], exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: no pause; 1: pause plen edges while showing step pstep;
    // 2: random pause and random start noise during the sweep.
    task automatic sweep(input int k, input int sim, input int hold, input int mode,
                         input int pstep, input int plen, input bit keep);
        int t, pcnt, tot;
        bit paused, p;
        tot = 2 * hold * sim * sim;
        start_r[k] = 1'b1;
        pause_r[k] = 1'b0;
        step();
        if (!keep) start_r[k] = 1'b0;
        t = 0;
        pcnt = 0;
        paused = 1'b0;
        forever begin
            chk(k, expv(sim, hold, t, paused), "sweep");
            if (t == tot) break;
            p = 1'b0;
            if (mode == 1 && t == pstep && pcnt < plen) p = 1'b1;
            if (mode == 2) begin
                p = ($urandom_range(0, 3) == 0);
                start_r[k] = ($urandom_range(0, 1) == 1);
            end
            pause_r[k] = p;
            step();
            if (p) begin
                paused = 1'b1;
                pcnt++;
            end else begin
                t++;
                paused = 1'b0;
            end
        end
        pause_r[k] = 1'b0;
        if (!keep) start_r[k] = 1'b0;
        step();
        chk(k, {4'd0, 1'b0, 1'b0, 9'(sim * sim - 1), 1'b0, 1'b0}, "idle_after_done");
    endtask

    initial begin
        rst_r   = '1;
        start_r = '0;
        pause_r = '0;
        step();
        step();
        for (int k = 0; k < ND; k++) chk(k, 17'd0, "reset");
        rst_r = '0;
        step();
        for (int k = 0; k < ND; k++) chk(k, 17'd0, "idle");

        // SIM=2 HOLD=1 plain sweep
        sweep(0, 2, 1, 0, 0, 0, 1'b0);
        // SIM=2 HOLD=3 plain sweep
        sweep(1, 2, 3, 0, 0, 0, 1'b0);
        // pause 5 cycles in the 2nd B_PH cycle of pair 1
        sweep(1, 2, 3, 1, 10, 5, 1'b0);

        // reset mid-sweep at sim_idx=2, then relaunch from pair 0
        start_r[0] = 1'b1;
        step();
        start_r[0] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            chk(0, expv(2, 1, t, 1'b0), "pre_reset");
            if (t < 4) step();
        end
        rst_r[0] = 1'b1;
        step();
        chk(0, 17'd0, "mid_reset");
        rst_r[0] = 1'b0;
        step();
        chk(0, 17'd0, "after_reset_no_done");
        sweep(0, 2, 1, 0, 0, 0, 1'b0);

        // start held high: ignored while busy, immediate relaunch after done
        sweep(0, 2, 1, 0, 0, 0, 1'b1);
        sweep(0, 2, 1, 0, 0, 0, 1'b0);

        // SIM=1 single pair
        sweep(2, 1, 1, 0, 0, 0, 1'b0);

        // randomized pauses and start noise
        sweep(3, 16, 1, 2, 0, 0, 1'b0);
        sweep(4, 3, 2, 2, 0, 0, 1'b0);
        sweep(4, 3, 2, 2, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
